// File: rtl/axi_rd_arbiter.sv
// Two-requester AXI4 read arbiter: shares one read master between I-cache (S0) and D-cache (S1) refills.
// Define AXI_RD_ARB_RR_EN for round-robin arbitration; default is fixed priority S1 > S0.
module axi_rd_arbiter #(
    parameter int unsigned C_M_AXI_THREAD_ID_WIDTH = 1,
    parameter int unsigned C_M_AXI_ADDR_WIDTH      = 32,
    parameter int unsigned C_M_AXI_DATA_WIDTH      = 32
) (
    input  logic                               CLK,
    input  logic                               RST_N,
    // requester 0 (instruction fetch cache)
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]      S0_ARADDR,
    input  logic [7:0]                         S0_ARLEN,
    input  logic                               S0_ARVALID,
    output logic                               S0_ARREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]      S0_RDATA,
    output logic [1:0]                         S0_RRESP,
    output logic                               S0_RLAST,
    output logic                               S0_RVALID,
    input  logic                               S0_RREADY,
    // requester 1 (data load cache)
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]      S1_ARADDR,
    input  logic [7:0]                         S1_ARLEN,
    input  logic                               S1_ARVALID,
    output logic                               S1_ARREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]      S1_RDATA,
    output logic [1:0]                         S1_RRESP,
    output logic                               S1_RLAST,
    output logic                               S1_RVALID,
    input  logic                               S1_RREADY,
    // shared AXI4 read master
    output logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_ARID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]      M_AXI_ARADDR,
    output logic [7:0]                         M_AXI_ARLEN,
    output logic [2:0]                         M_AXI_ARSIZE,
    output logic [1:0]                         M_AXI_ARBURST,
    output logic                               M_AXI_ARLOCK,
    output logic [3:0]                         M_AXI_ARCACHE,
    output logic [2:0]                         M_AXI_ARPROT,
    output logic [3:0]                         M_AXI_ARQOS,
    output logic [3:0]                         M_AXI_ARUSER,
    output logic                               M_AXI_ARVALID,
    input  logic                               M_AXI_ARREADY,
    input  logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_RID,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]      M_AXI_RDATA,
    input  logic [1:0]                         M_AXI_RRESP,
    input  logic                               M_AXI_RLAST,
    input  logic [3:0]                         M_AXI_RUSER,
    input  logic                               M_AXI_RVALID,
    output logic                               M_AXI_RREADY
);

    localparam int unsigned ID_W   = C_M_AXI_THREAD_ID_WIDTH;
    localparam int unsigned ADDR_W = C_M_AXI_ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic                grant, grant_nxt;
    logic [7:0]          beat_cnt, beat_cnt_nxt;
    logic [ADDR_W-1:0]   araddr, araddr_nxt;
    logic [7:0]          arlen, arlen_nxt;
    logic                pick_s1;
    logic                own_rready;
    logic                last_beat;
    logic                unused;

`ifdef AXI_RD_ARB_RR_EN
    logic                last_grant, last_grant_nxt;

    // On a tie the requester that did not win last time is served.
    assign pick_s1 = S1_ARVALID && (!S0_ARVALID || !last_grant);
`else
    assign pick_s1 = S1_ARVALID;
`endif

    assign own_rready = grant ? S1_RREADY : S0_RREADY;
    // Beat counter closes the burst even if the interconnect never raises RLAST.
    assign last_beat  = M_AXI_RLAST || (beat_cnt == arlen);

    // Read data and response are broadcast; only RVALID/RLAST are steered.
    assign S0_RDATA = M_AXI_RDATA;
    assign S1_RDATA = M_AXI_RDATA;
    assign S0_RRESP = M_AXI_RRESP;
    assign S1_RRESP = M_AXI_RRESP;

    assign M_AXI_ARID    = ID_W'(grant);
    assign M_AXI_ARADDR  = araddr;
    assign M_AXI_ARLEN   = arlen;
    assign M_AXI_ARSIZE  = 3'b010;
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARLOCK  = 1'b0;
    assign M_AXI_ARCACHE = 4'b0011;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARQOS   = 4'b0000;
    assign M_AXI_ARUSER  = 4'b0000;

    assign unused = ^{M_AXI_RID, M_AXI_RUSER};

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state    <= IDLE;
            grant    <= 1'b0;
            beat_cnt <= 8'd0;
            araddr   <= '0;
            arlen    <= 8'd0;
`ifdef AXI_RD_ARB_RR_EN
            last_grant <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            grant    <= grant_nxt;
            beat_cnt <= beat_cnt_nxt;
            araddr   <= araddr_nxt;
            arlen    <= arlen_nxt;
`ifdef AXI_RD_ARB_RR_EN
            last_grant <= last_grant_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt     = state;
        grant_nxt     = grant;
        beat_cnt_nxt  = beat_cnt;
        araddr_nxt    = araddr;
        arlen_nxt     = arlen;
`ifdef AXI_RD_ARB_RR_EN
        last_grant_nxt = last_grant;
`endif
        S0_ARREADY    = 1'b0;
        S1_ARREADY    = 1'b0;
        S0_RVALID     = 1'b0;
        S1_RVALID     = 1'b0;
        S0_RLAST      = 1'b0;
        S1_RLAST      = 1'b0;
        M_AXI_ARVALID = 1'b0;
        M_AXI_RREADY  = 1'b0;

        case (state)
            IDLE: begin
                // Accept is combinational, but never while reset is asserted.
                if (RST_N && (S0_ARVALID || S1_ARVALID)) begin
                    S1_ARREADY = pick_s1;
                    S0_ARREADY = !pick_s1;
                    grant_nxt  = pick_s1;
                    araddr_nxt = pick_s1 ? S1_ARADDR : S0_ARADDR;
                    arlen_nxt  = pick_s1 ? S1_ARLEN  : S0_ARLEN;
`ifdef AXI_RD_ARB_RR_EN
                    last_grant_nxt = pick_s1;
`endif
                    state_nxt  = ADDR;
                end
            end
            ADDR: begin
                M_AXI_ARVALID = 1'b1;
                if (M_AXI_ARREADY) begin
                    beat_cnt_nxt = 8'd0;
                    state_nxt    = DATA;
                end
            end
            DATA: begin
                M_AXI_RREADY = own_rready;
                if (grant) begin
                    S1_RVALID = M_AXI_RVALID;
                    S1_RLAST  = M_AXI_RVALID && last_beat;
                end else begin
                    S0_RVALID = M_AXI_RVALID;
                    S0_RLAST  = M_AXI_RVALID && last_beat;
                end
                if (M_AXI_RVALID && own_rready) begin
                    if (last_beat) begin
                        beat_cnt_nxt = 8'd0;
                        state_nxt    = IDLE;
                    end else begin
                        beat_cnt_nxt = beat_cnt + 8'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed self-checking bench for axi_rd_arbiter (works with or without AXI_RD_ARB_RR_EN).
module tb_axi_rd_arbiter;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [31:0] S0_ARADDR, S1_ARADDR;
    logic [7:0]  S0_ARLEN, S1_ARLEN;
    logic        S0_ARVALID, S1_ARVALID;
    logic        S0_ARREADY, S1_ARREADY;
    logic [31:0] S0_RDATA, S1_RDATA;
    logic [1:0]  S0_RRESP, S1_RRESP;
    logic        S0_RLAST, S1_RLAST;
    logic        S0_RVALID, S1_RVALID;
    logic        S0_RREADY, S1_RREADY;
    logic [0:0]  M_AXI_ARID;
    logic [31:0] M_AXI_ARADDR;
    logic [7:0]  M_AXI_ARLEN;
    logic [2:0]  M_AXI_ARSIZE;
    logic [1:0]  M_AXI_ARBURST;
    logic        M_AXI_ARLOCK;
    logic [3:0]  M_AXI_ARCACHE;
    logic [2:0]  M_AXI_ARPROT;
    logic [3:0]  M_AXI_ARQOS;
    logic [3:0]  M_AXI_ARUSER;
    logic        M_AXI_ARVALID;
    logic        M_AXI_ARREADY;
    logic [0:0]  M_AXI_RID;
    logic [31:0] M_AXI_RDATA;
    logic [1:0]  M_AXI_RRESP;
    logic        M_AXI_RLAST;
    logic [3:0]  M_AXI_RUSER;
    logic        M_AXI_RVALID;
    logic        M_AXI_RREADY;

    int checks = 0;
    int failures = 0;

    axi_rd_arbiter dut (
        .CLK(CLK), .RST_N(RST_N),
        .S0_ARADDR(S0_ARADDR), .S0_ARLEN(S0_ARLEN), .S0_ARVALID(S0_ARVALID), .S0_ARREADY(S0_ARREADY),
        .S0_RDATA(S0_RDATA), .S0_RRESP(S0_RRESP), .S0_RLAST(S0_RLAST), .S0_RVALID(S0_RVALID),
        .S0_RREADY(S0_RREADY),
        .S1_ARADDR(S1_ARADDR), .S1_ARLEN(S1_ARLEN), .S1_ARVALID(S1_ARVALID), .S1_ARREADY(S1_ARREADY),
        .S1_RDATA(S1_RDATA), .S1_RRESP(S1_RRESP), .S1_RLAST(S1_RLAST), .S1_RVALID(S1_RVALID),
        .S1_RREADY(S1_RREADY),
        .M_AXI_ARID(M_AXI_ARID), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN),
        .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_ARLOCK(M_AXI_ARLOCK),
        .M_AXI_ARCACHE(M_AXI_ARCACHE), .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARQOS(M_AXI_ARQOS),
        .M_AXI_ARUSER(M_AXI_ARUSER), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RID(M_AXI_RID), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RLAST(M_AXI_RLAST), .M_AXI_RUSER(M_AXI_RUSER), .M_AXI_RVALID(M_AXI_RVALID),
        .M_AXI_RREADY(M_AXI_RREADY)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are then driven and outputs sampled at +1.
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic        exp_s1;
        logic        rr;
        int          k;
        logic [31:0] hold_addr;

        RST_N = 1'b0;
        S0_ARADDR = '0; S0_ARLEN = '0; S0_ARVALID = 1'b0; S0_RREADY = 1'b0;
        S1_ARADDR = '0; S1_ARLEN = '0; S1_ARVALID = 1'b0; S1_RREADY = 1'b0;
        M_AXI_ARREADY = 1'b0; M_AXI_RID = '0; M_AXI_RDATA = '0; M_AXI_RRESP = 2'b00;
        M_AXI_RLAST = 1'b0; M_AXI_RUSER = '0; M_AXI_RVALID = 1'b0;

        // ---- reset state
        repeat (3) cyc();
        #1;
        chk("rst_arvalid", M_AXI_ARVALID, 0);
        chk("rst_s0_arready", S0_ARREADY, 0);
        chk("rst_s1_arready", S1_ARREADY, 0);
        chk("rst_rready", M_AXI_RREADY, 0);
        chk("rst_s0_rvalid", S0_RVALID, 0);
        chk("rst_arconst", {M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARCACHE}, {3'b010, 2'b01, 4'b0011});
        RST_N = 1'b1;
        cyc();

        // ---- single S0 burst, 8 beats
        S0_ARVALID = 1'b1; S0_ARADDR = 32'h2000_0000; S0_ARLEN = 8'd7; S0_RREADY = 1'b1; S1_RREADY = 1'b1;
        #1;
        chk("t1_s0_arready", S0_ARREADY, 1);
        chk("t1_s1_arready", S1_ARREADY, 0);
        chk("t1_arvalid_idle", M_AXI_ARVALID, 0);
        cyc();
        S0_ARVALID = 1'b0; M_AXI_ARREADY = 1'b1;
        #1;
        chk("t1_arvalid", M_AXI_ARVALID, 1);
        chk("t1_araddr", M_AXI_ARADDR, 32'h2000_0000);
        chk("t1_arlen", M_AXI_ARLEN, 8'd7);
        chk("t1_arid", M_AXI_ARID, 0);
        chk("t1_s0_arready_addr", S0_ARREADY, 0);
        cyc();
        M_AXI_ARREADY = 1'b0;
        for (int i = 0; i < 8; i++) begin
            M_AXI_RVALID = 1'b1; M_AXI_RDATA = 32'hA0 + i; M_AXI_RLAST = (i == 7);
            #1;
            chk("t1_s0_rvalid", S0_RVALID, 1);
            chk("t1_s0_rdata", S0_RDATA, 32'hA0 + i);
            chk("t1_s0_rlast", S0_RLAST, (i == 7) ? 1 : 0);
            chk("t1_s1_rvalid", S1_RVALID, 0);
            chk("t1_rready", M_AXI_RREADY, 1);
            cyc();
        end
        M_AXI_RVALID = 1'b0; M_AXI_RLAST = 1'b0;
        #1;
        chk("t1_idle_rready", M_AXI_RREADY, 0);
        chk("t1_idle_arvalid", M_AXI_ARVALID, 0);

        // ---- simultaneous ARLEN 0 requests, 4 rounds
        for (int r = 0; r < 4; r++) begin
`ifdef AXI_RD_ARB_RR_EN
            exp_s1 = (r % 2 == 0);
`else
            exp_s1 = 1'b1;
`endif
            S0_ARVALID = 1'b1; S0_ARADDR = 32'h2000_0000; S0_ARLEN = 8'd0;
            S1_ARVALID = 1'b1; S1_ARADDR = 32'h1000_0040; S1_ARLEN = 8'd0;
            #1;
            chk("t2_s1_arready", S1_ARREADY, exp_s1);
            chk("t2_s0_arready", S0_ARREADY, !exp_s1);
            cyc();
            S0_ARVALID = 1'b0; S1_ARVALID = 1'b0; M_AXI_ARREADY = 1'b1;
            #1;
            chk("t2_arid", M_AXI_ARID, exp_s1);
            chk("t2_araddr", M_AXI_ARADDR, exp_s1 ? 32'h1000_0040 : 32'h2000_0000);
            cyc();
            M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b1; M_AXI_RLAST = 1'b1; M_AXI_RDATA = 32'hC0 + r;
            #1;
            chk("t2_s1_rvalid", S1_RVALID, exp_s1);
            chk("t2_s0_rvalid", S0_RVALID, !exp_s1);
            cyc();
            M_AXI_RVALID = 1'b0; M_AXI_RLAST = 1'b0;
        end

        // ---- backpressure from S0 during a 4-beat burst
        S0_ARVALID = 1'b1; S0_ARADDR = 32'h2000_0100; S0_ARLEN = 8'd3;
        #1;
        chk("t3_s0_arready", S0_ARREADY, 1);
        cyc();
        S0_ARVALID = 1'b0; M_AXI_ARREADY = 1'b1;
        cyc();
        M_AXI_ARREADY = 1'b0;
        k = 0;
        for (int c = 0; c < 7; c++) begin
            rr = !(c >= 1 && c <= 3);
            S0_RREADY = rr; M_AXI_RVALID = 1'b1; M_AXI_RDATA = 32'hB0 + k; M_AXI_RLAST = (k == 3);
            #1;
            chk("t3_rready_follow", M_AXI_RREADY, rr);
            chk("t3_s0_rvalid", S0_RVALID, 1);
            chk("t3_s0_rdata", S0_RDATA, 32'hB0 + k);
            chk("t3_s0_rlast", S0_RLAST, (k == 3) ? 1 : 0);
            if (rr) k++;
            cyc();
        end
        M_AXI_RLAST = 1'b0; S0_RREADY = 1'b1;
        #1;
        chk("t3_idle_rready", M_AXI_RREADY, 0);
        chk("t3_idle_s0_rvalid", S0_RVALID, 0);
        M_AXI_RVALID = 1'b0;

        // ---- address stall of 5 cycles with a second S0 request pending
        S0_ARVALID = 1'b1; S0_ARADDR = 32'h2000_0200; S0_ARLEN = 8'd0;
        #1;
        chk("t4_s0_arready", S0_ARREADY, 1);
        cyc();
        hold_addr = 32'h2000_0200;
        S0_ARADDR = 32'h3000_0000; S0_ARLEN = 8'd3;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("t4_arvalid_hold", M_AXI_ARVALID, 1);
            chk("t4_araddr_hold", M_AXI_ARADDR, hold_addr);
            chk("t4_arlen_hold", M_AXI_ARLEN, 8'd0);
            chk("t4_s0_arready_hold", S0_ARREADY, 0);
            cyc();
        end
        M_AXI_ARREADY = 1'b1;
        cyc();
        M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b1; M_AXI_RLAST = 1'b1; M_AXI_RDATA = 32'hD0;
        #1;
        chk("t4_s0_arready_data", S0_ARREADY, 0);
        chk("t4_s0_rlast", S0_RLAST, 1);
        cyc();
        M_AXI_RVALID = 1'b0; M_AXI_RLAST = 1'b0;
        #1;
        chk("t4_s0_arready_idle", S0_ARREADY, 1);
        cyc();

        // ---- second request: ARLEN 3, interconnect never asserts RLAST
        S0_ARVALID = 1'b0; M_AXI_ARREADY = 1'b1;
        #1;
        chk("t5_araddr", M_AXI_ARADDR, 32'h3000_0000);
        chk("t5_arlen", M_AXI_ARLEN, 8'd3);
        cyc();
        M_AXI_ARREADY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            M_AXI_RVALID = 1'b1; M_AXI_RLAST = 1'b0; M_AXI_RDATA = 32'hE0 + i;
            #1;
            chk("t5_s0_rlast", S0_RLAST, (i == 3) ? 1 : 0);
            chk("t5_s0_rvalid", S0_RVALID, 1);
            cyc();
        end
        #1;
        chk("t5_idle_s0_rvalid", S0_RVALID, 0);
        chk("t5_idle_rready", M_AXI_RREADY, 0);
        M_AXI_RVALID = 1'b0;

        // ---- reset asserted during beat 2 of a burst
        S0_ARVALID = 1'b1; S0_ARADDR = 32'h2000_0300; S0_ARLEN = 8'd3;
        cyc();
        S0_ARVALID = 1'b0; M_AXI_ARREADY = 1'b1;
        cyc();
        M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b1; M_AXI_RDATA = 32'hF0;
        cyc();
        M_AXI_RDATA = 32'hF1; RST_N = 1'b0;
        #1;
        chk("t6_beat2_rvalid", S0_RVALID, 1);
        cyc();
        #1;
        chk("t6_rst_s0_rvalid", S0_RVALID, 0);
        chk("t6_rst_s0_rlast", S0_RLAST, 0);
        chk("t6_rst_rready", M_AXI_RREADY, 0);
        chk("t6_rst_arvalid", M_AXI_ARVALID, 0);
        chk("t6_rst_arready", {S0_ARREADY, S1_ARREADY}, 0);
        M_AXI_RVALID = 1'b0; RST_N = 1'b1;
        cyc();
        S1_ARVALID = 1'b1; S1_ARADDR = 32'h1000_0080; S1_ARLEN = 8'd0;
        #1;
        chk("t6_post_s1_arready", S1_ARREADY, 1);
        cyc();
        S1_ARVALID = 1'b0;
        #1;
        chk("t6_post_arid", M_AXI_ARID, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
